// File: rtl/weight_seq_pkg.sv
// Shared types and constants for the weight-load sequencer.
package weight_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLR       = 3'd1,
        ST_WSCLR     = 3'd2,
        ST_LOAD      = 3'd3,
        ST_WAIT_FULL = 3'd4,
        ST_COMPUTE   = 3'd5,
        ST_FIN       = 3'd6
    } state_t;

    // Largest legal filter height / width.
    localparam int MAX_RS = 5;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    // Wide enough for the largest legal timeout (65535).
    localparam int TIMER_W = 16;

    // A filter dimension is usable when it lies in 1..MAX_RS.
    function automatic logic dim_ok(input logic [3:0] v);
        return (v != 4'd0) && (v <= 4'(MAX_RS));
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counting dwell timer. o_tc flags the enabled cycle whose increment
// would bring the count to LIMIT, so the owner can react on that same edge.
module cycle_timer
    import weight_seq_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

    logic [TIMER_W-1:0] r_count;
    logic               w_at_last;

    assign w_at_last = (r_count == LAST);
    assign o_tc      = i_enable && w_at_last;

    // Count enabled cycles; saturate at the terminal value.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_last) begin
            r_count <= r_count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/weight_load_seq.sv
// Weight-load sequencer: clears the FIFO once per job, then for each filter
// clears the weight store, triggers a load, waits for the store to fill and
// holds WS_VALID until the compute engine reports completion.
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | no job; START with legal config launches one
// CLR        | one-cycle weight FIFO clear (once per job)
// WSCLR      | one-cycle weight store clear (every filter)
// LOAD       | one-cycle load trigger
// WAIT_FULL  | waiting for WS_FULL, bounded by the timeout timer
// COMPUTE    | weights valid until COMPUTE_DONE
// FIN        | one-cycle job-complete pulse
module weight_load_seq
    import weight_seq_pkg::*;
#(
    parameter int K_WIDTH        = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [3:0]         i_cfg_r,
    input  logic [3:0]         i_cfg_s,
    input  logic [K_WIDTH-1:0] i_cfg_k,
    input  logic               i_ws_full,
    input  logic               i_compute_done,
    output logic               o_clear_fifo,
    output logic               o_ws_clr,
    output logic               o_load_ws,
    output logic [3:0]         o_param_r,
    output logic [3:0]         o_param_s,
    output logic               o_ws_valid,
    output logic [K_WIDTH-1:0] o_filter_idx,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    state_t             r_state;
    logic [K_WIDTH-1:0] r_k;
    logic [K_WIDTH-1:0] r_filter_idx;
    logic [3:0]         r_param_r;
    logic [3:0]         r_param_s;
    logic               r_clear_fifo;
    logic               r_ws_clr;
    logic               r_load_ws;
    logic               r_ws_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic w_cfg_ok;
    logic w_last_filter;
    logic w_tmr_clear;
    logic w_tmr_en;
    logic w_tmr_tc;

    assign w_cfg_ok      = dim_ok(i_cfg_r) && dim_ok(i_cfg_s) && (i_cfg_k != '0);
    assign w_last_filter = (r_filter_idx == r_k - K_WIDTH'(1));

    // Timer is held clear outside WAIT_FULL, so it starts from zero on entry.
    assign w_tmr_clear = (r_state != ST_WAIT_FULL);
    assign w_tmr_en    = (r_state == ST_WAIT_FULL) && !i_ws_full;

    cycle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_en),
        .o_tc     (w_tmr_tc)
    );

    // Sequencer state and all registered outputs; pulses default low each cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_filter_idx <= '0;
            r_param_r    <= '0;
            r_param_s    <= '0;
            r_clear_fifo <= 1'b0;
            r_ws_clr     <= 1'b0;
            r_load_ws    <= 1'b0;
            r_ws_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_clear_fifo <= 1'b0;
            r_ws_clr     <= 1'b0;
            r_load_ws    <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;

            if (r_state != ST_IDLE && i_abort) begin
                r_state    <= ST_IDLE;
                r_ws_valid <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            if (w_cfg_ok) begin
                                r_param_r    <= i_cfg_r;
                                r_param_s    <= i_cfg_s;
                                r_k          <= i_cfg_k;
                                r_filter_idx <= '0;
                                r_clear_fifo <= 1'b1;
                                r_busy       <= 1'b1;
                                r_state      <= ST_CLR;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    ST_CLR: begin
                        r_ws_clr <= 1'b1;
                        r_state  <= ST_WSCLR;
                    end
                    ST_WSCLR: begin
                        r_load_ws <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        r_state <= ST_WAIT_FULL;
                    end
                    ST_WAIT_FULL: begin
                        if (i_ws_full) begin
                            r_ws_valid <= 1'b1;
                            r_state    <= ST_COMPUTE;
                        end else if (w_tmr_tc) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_COMPUTE: begin
                        if (i_compute_done) begin
                            r_ws_valid <= 1'b0;
                            if (w_last_filter) begin
                                r_done  <= 1'b1;
                                r_state <= ST_FIN;
                            end else begin
                                r_filter_idx <= r_filter_idx + K_WIDTH'(1);
                                r_ws_clr     <= 1'b1;
                                r_state      <= ST_WSCLR;
                            end
                        end
                    end
                    ST_FIN: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_ws_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_clear_fifo = r_clear_fifo;
    assign o_ws_clr     = r_ws_clr;
    assign o_load_ws    = r_load_ws;
    assign o_param_r    = r_param_r;
    assign o_param_s    = r_param_s;
    assign o_ws_valid   = r_ws_valid;
    assign o_filter_idx = r_filter_idx;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_weight_load_seq.sv
// Bench for weight_load_seq: jobs are described as per-filter wait / compute
// durations, expanded into a cycle-by-cycle schedule of expected outputs,
// then replayed against the DUT in lockstep.
module tb_weight_load_seq;

    localparam int KW = 8;
    localparam int TO = 8;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       abort;
        logic       full;
        logic       cdone;
        logic [3:0] r;
        logic [3:0] s;
        logic [7:0] k;
    } drv_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       clr;
        logic       wsclr;
        logic       load;
        logic       valid;
        logic [7:0] idx;
        logic [3:0] r;
        logic [3:0] s;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset, start, abort, ws_full, compute_done;
    logic [3:0]    cfg_r, cfg_s;
    logic [KW-1:0] cfg_k;
    logic          clear_fifo, ws_clr, load_ws, ws_valid, busy, done, err;
    logic [3:0]    param_r, param_s;
    logic [KW-1:0] filter_idx;

    drv_t plan_in[$];
    obs_t plan_exp[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_r, m_s;
    logic [7:0] m_idx;

    always #5 clk = ~clk;

    weight_load_seq #(
        .K_WIDTH        (KW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_abort        (abort),
        .i_cfg_r        (cfg_r),
        .i_cfg_s        (cfg_s),
        .i_cfg_k        (cfg_k),
        .i_ws_full      (ws_full),
        .i_compute_done (compute_done),
        .o_clear_fifo   (clear_fifo),
        .o_ws_clr       (ws_clr),
        .o_load_ws      (load_ws),
        .o_param_r      (param_r),
        .o_param_s      (param_s),
        .o_ws_valid     (ws_valid),
        .o_filter_idx   (filter_idx),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (busy,done,err,clr,wsclr,load,valid,idx,r,s)", tag, got, exp);
        end
    endtask

    function automatic obs_t mk(input bit b, input bit dn, input bit e, input bit c,
                                input bit w, input bit l, input bit v);
        obs_t o;
        o.busy  = b;
        o.done  = dn;
        o.err   = e;
        o.clr   = c;
        o.wsclr = w;
        o.load  = l;
        o.valid = v;
        o.idx   = m_idx;
        o.r     = m_r;
        o.s     = m_s;
        return o;
    endfunction

    // Background input noise: cfg wanders, stray WS_FULL / COMPUTE_DONE, optional held START.
    function automatic drv_t rnd_drv(input bit hold_start);
        drv_t d;
        d.rst   = 1'b0;
        d.start = hold_start ? 1'($urandom_range(0, 1)) : 1'b0;
        d.abort = 1'b0;
        d.full  = 1'($urandom_range(0, 1));
        d.cdone = ($urandom_range(0, 3) == 0);
        d.r     = 4'($urandom);
        d.s     = 4'($urandom);
        d.k     = 8'($urandom);
        return d;
    endfunction

    // kill_mode: 0 none, 1 abort, 2 reset; kill_at < 0 picks a random busy cycle.
    task automatic build_job(input int r, input int s, input int k, input int w_fix,
                             input int c_fix, input int kill_mode, input int kill_at,
                             input bit hold_start);
        drv_t jin[$];
        obs_t jexp[$];
        drv_t d;
        bit   legal;
        bit   timed_out;
        int   w, c, a;
        legal     = (r >= 1) && (r <= 5) && (s >= 1) && (s <= 5) && (k >= 1);
        timed_out = 1'b0;
        d       = rnd_drv(1'b0);
        d.start = 1'b1;
        d.r     = 4'(r);
        d.s     = 4'(s);
        d.k     = 8'(k);
        jin.push_back(d);
        jexp.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        if (!legal) begin
            jin.push_back(rnd_drv(1'b0));
            jexp.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        end else begin
            m_r   = 4'(r);
            m_s   = 4'(s);
            m_idx = 8'd0;
            jin.push_back(rnd_drv(hold_start));
            jexp.push_back(mk(1, 0, 0, 1, 0, 0, 0));
            for (int f = 0; f < k; f++) begin
                m_idx = 8'(f);
                jin.push_back(rnd_drv(hold_start));
                jexp.push_back(mk(1, 0, 0, 0, 1, 0, 0));
                jin.push_back(rnd_drv(hold_start));
                jexp.push_back(mk(1, 0, 0, 0, 0, 1, 0));
                if (w_fix >= 0) w = w_fix;
                else if ($urandom_range(0, 7) == 0) w = int'($urandom_range(TO, TO + 2));
                else w = int'($urandom_range(0, 5));
                c = (c_fix >= 0) ? c_fix : int'($urandom_range(1, 6));
                if (w >= TO) begin
                    for (int j = 0; j < TO; j++) begin
                        d      = rnd_drv(hold_start);
                        d.full = 1'b0;
                        jin.push_back(d);
                        jexp.push_back(mk(1, 0, 0, 0, 0, 0, 0));
                    end
                    jin.push_back(rnd_drv(1'b0));
                    jexp.push_back(mk(0, 0, 1, 0, 0, 0, 0));
                    timed_out = 1'b1;
                    break;
                end
                for (int j = 0; j < w; j++) begin
                    d      = rnd_drv(hold_start);
                    d.full = 1'b0;
                    jin.push_back(d);
                    jexp.push_back(mk(1, 0, 0, 0, 0, 0, 0));
                end
                d      = rnd_drv(hold_start);
                d.full = 1'b1;
                jin.push_back(d);
                jexp.push_back(mk(1, 0, 0, 0, 0, 0, 0));
                for (int j = 0; j < c; j++) begin
                    d       = rnd_drv(hold_start);
                    d.cdone = (j == c - 1);
                    jin.push_back(d);
                    jexp.push_back(mk(1, 0, 0, 0, 0, 0, 1));
                end
            end
            if (!timed_out) begin
                jin.push_back(rnd_drv(hold_start));
                jexp.push_back(mk(1, 1, 0, 0, 0, 0, 0));
            end
        end
        a = jin.size() - 1;
        if (kill_mode != 0 && legal) begin
            a = (kill_at >= 0) ? kill_at : int'($urandom_range(1, jin.size() - 2));
            if (kill_mode == 1) jin[a].abort = 1'b1;
            else jin[a].rst = 1'b1;
            if (kill_mode == 2) begin
                m_r   = 4'd0;
                m_s   = 4'd0;
                m_idx = 8'd0;
            end else begin
                m_r   = jexp[a].r;
                m_s   = jexp[a].s;
                m_idx = jexp[a].idx;
            end
        end
        for (int i = 0; i <= a; i++) begin
            plan_in.push_back(jin[i]);
            plan_exp.push_back(jexp[i]);
        end
    endtask

    task automatic run_plan();
        obs_t o;
        for (int i = 0; i < plan_in.size(); i++) begin
            o.busy  = busy;
            o.done  = done;
            o.err   = err;
            o.clr   = clear_fifo;
            o.wsclr = ws_clr;
            o.load  = load_ws;
            o.valid = ws_valid;
            o.idx   = filter_idx;
            o.r     = param_r;
            o.s     = param_s;
            chk($sformatf("cyc%0d", i), {9'd0, o}, {9'd0, plan_exp[i]});
            reset        = plan_in[i].rst;
            start        = plan_in[i].start;
            abort        = plan_in[i].abort;
            ws_full      = plan_in[i].full;
            compute_done = plan_in[i].cdone;
            cfg_r        = plan_in[i].r;
            cfg_s        = plan_in[i].s;
            cfg_k        = plan_in[i].k;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int r, s, k, km;
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        ws_full      = 1'b0;
        compute_done = 1'b0;
        cfg_r        = 4'd0;
        cfg_s        = 4'd0;
        cfg_k        = '0;
        m_r          = 4'd0;
        m_s          = 4'd0;
        m_idx        = 8'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reference job: R=3 S=3 K=2, WS_FULL 4 cycles after LOAD_WS, compute 10 cycles.
        build_job(3, 3, 2, 3, 10, 0, 0, 1'b0);
        // Illegal configurations.
        build_job(6, 3, 2, 0, 1, 0, 0, 1'b0);
        build_job(3, 3, 0, 0, 1, 0, 0, 1'b0);
        build_job(0, 5, 1, 0, 1, 0, 0, 1'b0);
        // Timeout on first filter.
        build_job(2, 2, 1, TO, 1, 0, 0, 1'b0);
        // Boundary dims, then abort in COMPUTE of filter 1 of 3, then a normal job.
        build_job(5, 1, 1, 0, 1, 0, 0, 1'b0);
        build_job(4, 5, 3, 0, 5, 1, 14, 1'b0);
        build_job(4, 5, 3, 0, 5, 0, 0, 1'b0);
        // Reset during WAIT_FULL with START held, then a job with START held.
        build_job(3, 3, 2, 5, 4, 2, 6, 1'b1);
        build_job(1, 1, 1, -1, -1, 0, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            r  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(6, 15)) : int'($urandom_range(1, 5));
            s  = int'($urandom_range(1, 5));
            k  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            km = int'($urandom_range(0, 7));
            km = (km == 0) ? 1 : (km == 1) ? 2 : 0;
            build_job(r, s, k, -1, -1, km, -1, 1'($urandom_range(0, 1)));
        end

        plan_in.push_back(rnd_drv(1'b0));
        plan_exp.push_back(mk(0, 0, 0, 0, 0, 0, 0));

        run_plan();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
